int_dot_accumulator: RTL and testbench

- Sequential accumulator directly downstream of the integer adder-tree nodes.
- Consumes a stream of partial sums from the root of an adder tree, one per beat.
- Sums NUM_CHUNKS consecutive partial sums into one full-width dot-product result.
- Presents each result on a valid/ready output interface for the next stage (requantiser / writeback).

---
 rtl/int_dot_accumulator.sv | 100 ++++++++++
 tb/tb_int_dot_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/int_dot_accumulator.sv
// int_dot_accumulator: sums NUM_CHUNKS consecutive adder-tree partial sums
// into one OUT_BITS-wide dot-product result, presented on valid/ready.
module int_dot_accumulator #(
    parameter int unsigned IN_BITS    = 17,
    parameter int unsigned OUT_BITS   = 32,
    parameter int unsigned NUM_CHUNKS = 8,
    parameter int          SIGN_EXT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_BITS-1:0]  in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int unsigned CNT_BITS = $clog2(NUM_CHUNKS) + 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NUM_CHUNKS - 1);

    // Parameter sanity: the accumulator must hold NUM_CHUNKS full-scale inputs.
    if (NUM_CHUNKS < 1) begin : g_bad_chunks
        $fatal(1, "int_dot_accumulator: NUM_CHUNKS must be >= 1");
    end
    if (OUT_BITS < IN_BITS + $clog2(NUM_CHUNKS)) begin : g_bad_width
        $fatal(1, "int_dot_accumulator: OUT_BITS too narrow for IN_BITS and NUM_CHUNKS");
    end

    logic [OUT_BITS-1:0] r_acc;
    logic [CNT_BITS-1:0] r_count;
    logic [OUT_BITS-1:0] r_out_data;
    logic                r_out_valid;

    logic [OUT_BITS-1:0] w_ext;
    logic [OUT_BITS-1:0] w_sum;
    logic                w_last;
    logic                w_in_ready;
    logic                w_accept;
    logic [OUT_BITS-1:0] w_acc_nxt;
    logic [CNT_BITS-1:0] w_count_nxt;
    logic [OUT_BITS-1:0] w_out_data_nxt;
    logic                w_out_valid_nxt;

    // Widen the incoming partial sum to accumulator width.
    always_comb begin
        w_ext = OUT_BITS'(in_data);
        if (SIGN_EXT != 0) begin
            w_ext = OUT_BITS'($signed(in_data));
        end
    end

    // Handshake decode; a first beat overwrites acc so no clear cycle is needed.
    always_comb begin
        w_last     = (r_count == LAST_CNT);
        w_in_ready = !(w_last && r_out_valid && !out_ready);
        w_accept   = in_valid && w_in_ready;
        w_sum      = (r_count == '0) ? w_ext : (r_acc + w_ext);
    end

    // Next-state: accumulate non-last beats, load the result on the last one.
    always_comb begin
        w_acc_nxt       = r_acc;
        w_count_nxt     = r_count;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid && !out_ready;
        if (w_accept) begin
            if (w_last) begin
                w_out_data_nxt  = w_sum;
                w_out_valid_nxt = 1'b1;
                w_count_nxt     = '0;
            end else begin
                w_acc_nxt   = w_sum;
                w_count_nxt = r_count + CNT_BITS'(1);
            end
        end
    end

    // State registers; reset discards any partial sum and pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_count     <= w_count_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_count != '0);

endmodule

// File: tb/tb_int_dot_accumulator.sv
// Self-checking bench for int_dot_accumulator across four parameterisations
// sharing one stimulus bus; each scenario resets and observes one instance.
module tb_int_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        ir [4];
    logic [31:0] od [4];
    logic        ov [4];
    logic        bz [4];

    int chunks_of [4] = '{4, 4, 8, 1};
    bit sext_of   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // 0: N=4 signed, 1: N=4 unsigned, 2: N=8 signed, 3: N=1 signed
    int_dot_accumulator #(.IN_BITS(17), .OUT_BITS(32), .NUM_CHUNKS(4), .SIGN_EXT(1)) dut_s4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]));
    int_dot_accumulator #(.IN_BITS(17), .OUT_BITS(32), .NUM_CHUNKS(4), .SIGN_EXT(0)) dut_u4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]));
    int_dot_accumulator #(.IN_BITS(17), .OUT_BITS(32), .NUM_CHUNKS(8), .SIGN_EXT(1)) dut_s8 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .busy(bz[2]));
    int_dot_accumulator #(.IN_BITS(17), .OUT_BITS(32), .NUM_CHUNKS(1), .SIGN_EXT(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[3]),
        .out_data(od[3]), .out_valid(ov[3]), .out_ready(out_ready), .busy(bz[3]));

    function automatic longint ext_val(input logic [16:0] v, input bit s);
        if (s) return longint'($signed(v));
        return longint'(v);
    endfunction

    task automatic reset_dut();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [16:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 4; s++) begin
            n_cmp++; if (ov[s] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d] got %b want 0", s, ov[s]); end
            n_cmp++; if (od[s] !== 32'h0) begin n_fail++; $display("FAIL reset_out_data[%0d] got %h want 0", s, od[s]); end
            n_cmp++; if (bz[s] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", s, bz[s]); end
            n_cmp++; if (ir[s] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d] got %b want 1", s, ir[s]); end
        end
        reset_dut();
    endtask

    task automatic test_signed();
        logic [16:0] v [4];
        logic        exp_bz [4];
        v = '{17'd5, 17'h1FFFD, 17'd100, 17'h10000};
        exp_bz = '{1'b1, 1'b1, 1'b1, 1'b0};
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(v[i]);
            n_cmp++; if (bz[0] !== exp_bz[i]) begin n_fail++; $display("FAIL signed_busy beat %0d got %b want %b", i, bz[0], exp_bz[i]); end
            n_cmp++; if (ov[0] !== (i == 3)) begin n_fail++; $display("FAIL signed_valid beat %0d got %b want %b", i, ov[0], i == 3); end
        end
        n_cmp++; if (od[0] !== 32'hFFFF0066) begin n_fail++; $display("FAIL signed_sum got %h want ffff0066", od[0]); end
        @(posedge clk); #1;
        n_cmp++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL signed_valid_pulse got %b want 0", ov[0]); end
    endtask

    task automatic test_unsigned();
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive(17'h1FFFF);
        n_cmp++; if (ov[1] !== 1'b1) begin n_fail++; $display("FAIL unsigned_valid got %b want 1", ov[1]); end
        n_cmp++; if (od[1] !== 32'h0007FFFC) begin n_fail++; $display("FAIL unsigned_sum got %h want 0007fffc", od[1]); end
    endtask

    task automatic test_backpressure();
        reset_dut();
        out_ready = 1'b1;
        drive(17'd1); drive(17'd2); drive(17'd3);
        out_ready = 1'b0;
        drive(17'd4);
        n_cmp++; if (od[0] !== 32'd10 || ov[0] !== 1'b1) begin n_fail++; $display("FAIL bp_result_a got %0d/%b want 10/1", od[0], ov[0]); end
        for (int i = 0; i < 3; i++) begin
            in_data = 17'd1; in_valid = 1'b1; #1;
            n_cmp++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_nonlast_ready beat %0d got %b want 1", i, ir[0]); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; #1;
        n_cmp++; if (od[0] !== 32'd10 || ov[0] !== 1'b1) begin n_fail++; $display("FAIL bp_stall_hold got %0d/%b want 10/1", od[0], ov[0]); end
        in_valid = 1'b1; #1;
        n_cmp++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL bp_last_blocked got %b want 0", ir[0]); end
        @(posedge clk); #1;
        n_cmp++; if (od[0] !== 32'd10 || ov[0] !== 1'b1 || bz[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_still_stalled got %0d/%b/%b want 10/1/1", od[0], ov[0], bz[0]);
        end
        out_ready = 1'b1; #1;
        n_cmp++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_on_drain got %b want 1", ir[0]); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (od[0] !== 32'd4 || ov[0] !== 1'b1 || bz[0] !== 1'b0) begin
            n_fail++; $display("FAIL bp_result_b got %0d/%b/%b want 4/1/0", od[0], ov[0], bz[0]);
        end
        @(posedge clk); #1;
        n_cmp++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b want 0", ov[0]); end
    endtask

    task automatic test_random(input int s, input int groups, input int gap_pct);
        logic [31:0] expq [$];
        logic [31:0] e;
        longint      acc;
        int          k, sent, got, total;
        acc = 0; k = 0; sent = 0; got = 0;
        total = groups * chunks_of[s];
        reset_dut();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 2000 && (sent < total || expq.size() != 0); cyc++) begin
            in_valid = (sent < total) && ($urandom_range(99) >= gap_pct);
            in_data  = 17'($urandom);
            #1;
            if (ov[s] && out_ready) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL rand[%0d]_spurious got %h want no result", s, od[s]);
                end else begin
                    e = expq.pop_front();
                    if (od[s] !== e) begin n_fail++; $display("FAIL rand[%0d]_result %0d got %h want %h", s, got, od[s], e); end
                end
                got++;
            end
            if (gap_pct == 0 && sent < total) begin
                n_cmp++; if (ir[s] !== 1'b1) begin n_fail++; $display("FAIL rand[%0d]_throughput got in_ready %b want 1", s, ir[s]); end
            end
            if (gap_pct == 0 && chunks_of[s] == 1 && sent > 0) begin
                n_cmp++; if (ov[s] !== 1'b1) begin n_fail++; $display("FAIL rand[%0d]_b2b_valid got %b want 1", s, ov[s]); end
            end
            if (in_valid && ir[s]) begin
                acc += ext_val(in_data, sext_of[s]);
                k++; sent++;
                if (k == chunks_of[s]) begin
                    expq.push_back(32'(acc));
                    acc = 0; k = 0;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (got !== groups) begin n_fail++; $display("FAIL rand[%0d]_count got %0d want %0d", s, got, groups); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        out_ready = 1'b1;
        drive(17'd7); drive(17'd9);
        n_cmp++; if (bz[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", bz[0]); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== 32'h0) begin
            n_fail++; $display("FAIL rmid_in_reset got v%b b%b r%b d%h want v0 b0 r1 d0", ov[0], bz[0], ir[0], od[0]);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (ov[0] !== 1'b0 || bz[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_after got v%b b%b want v0 b0", ov[0], bz[0]); end
        for (int i = 0; i < 3; i++) drive(17'd1);
        n_cmp++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_no_spurious got %b want 0", ov[0]); end
        drive(17'd1);
        n_cmp++; if (od[0] !== 32'd4 || ov[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_result got %0d/%b want 4/1", od[0], ov[0]); end
    endtask

    task automatic test_single_chunk();
        reset_dut();
        out_ready = 1'b1;
        drive(17'd7);
        n_cmp++; if (od[3] !== 32'd7 || ov[3] !== 1'b1) begin n_fail++; $display("FAIL n1_first got %h/%b want 7/1", od[3], ov[3]); end
        drive(17'h1FFFF);
        n_cmp++; if (od[3] !== 32'hFFFFFFFF || ov[3] !== 1'b1) begin n_fail++; $display("FAIL n1_second got %h/%b want ffffffff/1", od[3], ov[3]); end
        @(posedge clk); #1;
        n_cmp++; if (ov[3] !== 1'b0 || bz[3] !== 1'b0) begin n_fail++; $display("FAIL n1_idle got v%b b%b want v0 b0", ov[3], bz[3]); end
    endtask

    initial begin
        #3;
        test_reset();
        test_signed();
        test_unsigned();
        test_backpressure();
        test_random(2, 3, 35);
        test_random(0, 4, 25);
        test_random(1, 3, 20);
        test_random(2, 3, 0);
        test_random(3, 6, 0);
        test_reset_mid();
        test_single_chunk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
